// File: rtl/linea_retardo_pkg.sv
// Shared definitions for the linea_retardo tapped delay line.
// Holds the stream FSM encoding and the default sample width and tap count.
package linea_retardo_pkg;

    localparam int DEFAULT_WIDTH = 23;
    localparam int DEFAULT_DEPTH = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

endpackage

// File: rtl/linea_retardo_if.sv
// Bundles the sample strobe, the tap bus and the status flags of linea_retardo.
// The controller drives through master; the delay line answers through slave.
interface linea_retardo_if #(
    parameter int WIDTH = 23,
    parameter int DEPTH = 8
) ();

    localparam int IDX_W = $clog2(DEPTH);

    logic                   enable;
    logic                   clear;
    logic [WIDTH-1:0]       datoIn;
    logic [WIDTH*DEPTH-1:0] taps;
    logic [WIDTH-1:0]       tapOut;
    logic [IDX_W-1:0]       tapIdx;
    logic                   tapValid;
    logic                   tapLast;
    logic                   busy;
    logic                   lleno;
    logic                   overrun;

    modport master (
        output enable, clear, datoIn,
        input  taps, tapOut, tapIdx, tapValid, tapLast, busy, lleno, overrun
    );

    modport slave (
        input  enable, clear, datoIn,
        output taps, tapOut, tapIdx, tapValid, tapLast, busy, lleno, overrun
    );

endinterface

// File: rtl/linea_retardo_registro_tap.sv
// One stage of the delay line: a WIDTH-bit register that loads on enable.
// clear wins over enable so a flush never lets a sample slip in.
module registro_tap
    import linea_retardo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             clear,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clear) begin
            q <= '0;
        end else if (enable) begin
            q <= d;
        end
    end

endmodule

// File: rtl/linea_retardo.sv
// Tapped delay line: all taps in parallel plus a serial replay of the taps
// (newest first) after every accepted sample, with fill and overrun flags.
module linea_retardo
    import linea_retardo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic                   clk44kHz,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic                   clear,
    input  logic [WIDTH-1:0]       datoIn,
    output logic [WIDTH*DEPTH-1:0] taps,
    output logic [WIDTH-1:0]       tapOut,
    output logic [IDX_W-1:0]       tapIdx,
    output logic                   tapValid,
    output logic                   tapLast,
    output logic                   busy,
    output logic                   lleno,
    output logic                   overrun
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] line [DEPTH];
    logic             shift;
    state_t           state;
    logic [IDX_W-1:0] tap_idx;
    logic             last_q;
    logic             overrun_q;
    logic [CNT_W-1:0] fill_count;
    logic             lleno_q;

    assign shift = enable & ~clear;

    genvar k;
    generate
        for (k = 0; k < DEPTH; k++) begin : g_tap
            logic [WIDTH-1:0] d_in;
            if (k == 0) begin : g_first
                assign d_in = datoIn;
            end else begin : g_next
                assign d_in = line[k-1];
            end

            registro_tap #(
                .WIDTH (WIDTH)
            ) u_tap (
                .clk    (clk44kHz),
                .rst_n  (reset_n),
                .enable (shift),
                .clear  (clear),
                .d      (d_in),
                .q      (line[k])
            );

            assign taps[k*WIDTH +: WIDTH] = line[k];
        end
    endgenerate

    // Counts real samples since the last flush; stops counting once full.
    always_ff @(posedge clk44kHz or negedge reset_n) begin
        if (!reset_n) begin
            fill_count <= '0;
            lleno_q    <= 1'b0;
        end else if (clear) begin
            fill_count <= '0;
            lleno_q    <= 1'b0;
        end else if (shift && !lleno_q) begin
            fill_count <= fill_count + CNT_W'(1);
            lleno_q    <= (fill_count == CNT_W'(DEPTH - 1));
        end
    end

    // last_q marks tap_idx == DEPTH-1, so a shift while it is low is an abort.
    always_ff @(posedge clk44kHz or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            tap_idx   <= '0;
            last_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else if (clear) begin
            state     <= IDLE;
            tap_idx   <= '0;
            last_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (shift) begin
                        state   <= STREAM;
                        tap_idx <= '0;
                        last_q  <= 1'b0;
                    end
                end
                STREAM: begin
                    if (shift) begin
                        tap_idx <= '0;
                        last_q  <= 1'b0;
                        if (!last_q) begin
                            overrun_q <= 1'b1;
                        end
                    end else if (last_q) begin
                        state   <= IDLE;
                        tap_idx <= '0;
                        last_q  <= 1'b0;
                    end else begin
                        tap_idx <= tap_idx + IDX_W'(1);
                        last_q  <= (tap_idx == IDX_W'(DEPTH - 2));
                    end
                end
                default: begin
                    state   <= IDLE;
                    tap_idx <= '0;
                    last_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = (state == STREAM);
    assign tapValid = (state == STREAM);
    assign tapIdx   = tap_idx;
    assign tapLast  = last_q;
    assign tapOut   = (state == STREAM) ? line[tap_idx] : '0;
    assign lleno    = lleno_q;
    assign overrun  = overrun_q;

endmodule

// File: doc/linea_retardo.md
LINEA_RETARDO -- requirements
Module: linea_retardo

Interface
REQ-001 SHALL have parameter WIDTH, default 23, sample width in bits.
REQ-002 SHALL have parameter DEPTH, default 8, number of taps (legal range 2..64).
REQ-003 SHALL have a local parameter IDX_W equal to ceil(log2(DEPTH)), giving the tap index width.
REQ-004 SHALL have port clk44kHz, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit, the reset; reset is asynchronous and active-low.
REQ-006 SHALL have port enable, input, 1 bit, sample strobe: shift datoIn into the line this edge.
REQ-007 SHALL have port clear, input, 1 bit, synchronous flush of line, counters and flags.
REQ-008 SHALL have port datoIn, input, WIDTH bits, the new sample.
REQ-009 SHALL have port taps, output, WIDTH*DEPTH bits, all taps in parallel; tap k at bits [k*WIDTH +: WIDTH]; tap 0 is newest.
REQ-010 SHALL have port tapOut, output, WIDTH bits, serial tap stream data.
REQ-011 SHALL have port tapIdx, output, IDX_W bits, index of the tap currently on tapOut.
REQ-012 SHALL have port tapValid, output, 1 bit, tapOut/tapIdx are valid this cycle.
REQ-013 SHALL have port tapLast, output, 1 bit, high with the final tap (index DEPTH-1) of a stream.
REQ-014 SHALL have port busy, output, 1 bit, serial stream in progress.
REQ-015 SHALL have port lleno, output, 1 bit, line holds DEPTH real samples since last clear/reset.
REQ-016 SHALL have port overrun, output, 1 bit, sticky: a stream was aborted by a new sample.

Function
REQ-017 Shift: edge with enable=1 and clear=0 -> tap0<=datoIn, tap k<=tap k-1 (k=1..DEPTH-1); oldest discarded; enable=0 -> all taps hold.
REQ-018 clear=1 SHALL take priority over enable: taps, fill count, lleno, overrun <= 0, FSM -> IDLE, tapIdx <= 0; sample on datoIn not taken.
REQ-019 Fill counter SHALL increment on each accepted shift, saturate at DEPTH; lleno = (count==DEPTH), registered, rising on the edge of the DEPTH-th shift.
REQ-020 FSM states SHALL be IDLE and STREAM; busy=1 and tapValid=1 exactly in STREAM.
REQ-021 IDLE + accepted shift -> STREAM with tapIdx=0 on the next cycle (latency 1 edge from the enable edge).
REQ-022 In STREAM, tapOut SHALL equal tap[tapIdx] of the current (post-shift) line; tapIdx increments by 1 per cycle.
REQ-023 tapLast SHALL be 1 when in STREAM and tapIdx==DEPTH-1; next edge -> IDLE unless a shift is accepted.
REQ-024 Accepted shift on the tapLast cycle SHALL restart the stream at tapIdx=0 with no overrun (back-to-back).
REQ-025 Accepted shift in STREAM with tapIdx<DEPTH-1 SHALL still shift, restart tapIdx at 0, stay in STREAM, set overrun.
REQ-026 overrun SHALL stay 1 until clear or reset.
REQ-027 Outside STREAM: tapOut=0, tapIdx=0, tapValid=0, tapLast=0.
REQ-028 The block SHALL perform no arithmetic on samples; data is passed bit-exact.

Reset
REQ-029 reset_n low SHALL immediately force all taps, fill count, tapIdx, lleno, overrun to 0 and FSM to IDLE, independent of clock.
REQ-030 Reset asserted mid-stream SHALL abort the stream with no tapLast; after release the first accepted shift starts a fresh stream.
REQ-031 All outputs SHALL read 0 during and directly after reset.

Structure
REQ-032 FSM state encoding (IDLE=0, STREAM=1) and default WIDTH/DEPTH SHALL live in the shared filter package/include.
REQ-033 One tap stage SHALL be a sub-module registro_tap (WIDTH-bit register, enable, clear, async active-low reset), instantiated DEPTH times by generate.

Verification (bench WIDTH=8, DEPTH=4)
REQ-034 Reset, then shift 0x11,0x22,0x33,0x44 on spaced enables -> taps = {0x11,0x22,0x33,0x44} (tap3..tap0), lleno rises on the 4th shift edge.
REQ-035 Isolated shift of 0x55 on a full line -> next 4 cycles tapIdx 0..3, tapOut 0x55,0x44,0x33,0x22, tapLast on the 4th, then busy=0.
REQ-036 Second shift 0x66 when tapIdx=1 -> line shifts, tapIdx restarts at 0 with tapOut 0x66, overrun=1 and stays 1.
REQ-037 Shift on the tapLast cycle -> next cycle tapIdx=0, busy=1, overrun stays 0.
REQ-038 clear and enable together mid-stream -> all taps 0, busy=0, lleno=0, overrun=0, datoIn not stored.
REQ-039 reset_n pulsed low between clock edges during a stream -> outputs 0 immediately, no tapLast emitted.
